// File: rtl/sort_pkg.sv
// Shared constants and elaboration helpers for the bitonic sorting pipeline.
package sort_pkg;

    localparam int unsigned NETWORK_WIDTH = 16;
    localparam int unsigned INDEX_WIDTH   = 5;

    typedef enum logic {
        DIR_ASC  = 1'b0,
        DIR_DESC = 1'b1
    } sort_dir_e;

    function automatic int unsigned sort_stages(input int unsigned log_lanes);
        return log_lanes * (log_lanes + 1) / 2;
    endfunction

    function automatic sort_dir_e pair_dir(input int unsigned k, input int unsigned i,
                                           input logic descend);
        logic blk_desc;
        blk_desc = ((i >> k) & 32'd1) != 32'd0;
        return (blk_desc ^ descend) ? DIR_DESC : DIR_ASC;
    endfunction

    // Layer s enumerates k = 1..log_lanes, and within each k, j = k-1 down to 0.
    function automatic int unsigned stage_k(input int unsigned log_lanes, input int unsigned s);
        int unsigned n;
        n = 0;
        for (int unsigned k = 1; k <= log_lanes; k++) begin
            for (int unsigned j = k; j > 0; j--) begin
                if (n == s) return k;
                n++;
            end
        end
        return 0;
    endfunction

    function automatic int unsigned stage_j(input int unsigned log_lanes, input int unsigned s);
        int unsigned n;
        n = 0;
        for (int unsigned k = 1; k <= log_lanes; k++) begin
            for (int unsigned j = k; j > 0; j--) begin
                if (n == s) return j - 1;
                n++;
            end
        end
        return 0;
    endfunction

endpackage

// File: rtl/cmp_exchange_layer.sv
// One registered compare-exchange layer of the bitonic network (pair distance 2**J, block size 2**K).
// BITONIC_SORT_INDEX_EN adds index registers and index-based tie breaking.
module cmp_exchange_layer
    import sort_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = NETWORK_WIDTH,
    parameter int unsigned IDX_W  = INDEX_WIDTH,
    parameter int unsigned J      = 0,
    parameter int unsigned K      = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up_valid,
    input  logic                    up_descend,
    input  logic [LANES*DATA_W-1:0] up_data,
    input  logic [LANES*IDX_W-1:0]  up_index,
    output logic                    valid,
    output logic                    descend,
    output logic [LANES*DATA_W-1:0] data,
    output logic [LANES*IDX_W-1:0]  index
);

    logic [LANES*DATA_W-1:0] nxt_data;
`ifdef BITONIC_SORT_INDEX_EN
    logic [LANES*IDX_W-1:0]  nxt_index;
`endif

    for (genvar p = 0; p < LANES / 2; p++) begin : g_pair
        // Insert a zero at bit J of the pair number to get the lower lane.
        localparam int unsigned PN = p;
        localparam int unsigned LO = ((PN >> J) << (J + 1)) | (PN & ((1 << J) - 1));
        localparam int unsigned HI = LO | (1 << J);

        logic [DATA_W-1:0] lo_val, hi_val;
        logic              tie_swap, swap;
        sort_dir_e         dir;

        assign lo_val = up_data[LO*DATA_W +: DATA_W];
        assign hi_val = up_data[HI*DATA_W +: DATA_W];
        assign dir    = pair_dir(K, LO, up_descend);

`ifdef BITONIC_SORT_INDEX_EN
        logic [IDX_W-1:0] lo_idx, hi_idx;
        assign lo_idx   = up_index[LO*IDX_W +: IDX_W];
        assign hi_idx   = up_index[HI*IDX_W +: IDX_W];
        assign tie_swap = (lo_val == hi_val) && (lo_idx > hi_idx);
        assign nxt_index[LO*IDX_W +: IDX_W] = swap ? hi_idx : lo_idx;
        assign nxt_index[HI*IDX_W +: IDX_W] = swap ? lo_idx : hi_idx;
`else
        assign tie_swap = 1'b0;
`endif

        assign swap = (dir == DIR_DESC) ? ((lo_val < hi_val) || tie_swap)
                                        : ((lo_val > hi_val) || tie_swap);
        assign nxt_data[LO*DATA_W +: DATA_W] = swap ? hi_val : lo_val;
        assign nxt_data[HI*DATA_W +: DATA_W] = swap ? lo_val : hi_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            descend <= 1'b0;
            data    <= '0;
        end else if (en) begin
            valid <= up_valid;
            if (up_valid) begin
                descend <= up_descend;
                data    <= nxt_data;
            end
        end
    end

`ifdef BITONIC_SORT_INDEX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index <= '0;
        end else if (en && up_valid) begin
            index <= nxt_index;
        end
    end
`else
    logic unused_up_index;
    assign unused_up_index = ^up_index;
    assign index = '0;
`endif

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorting network with valid/ready flow control and runtime direction.
// Define BITONIC_SORT_INDEX_EN to carry per-lane indices and break value ties by index.
module bitonic_sort_pipe
    import sort_pkg::*;
#(
    parameter  int unsigned LOG_LANES = 2,
    parameter  int unsigned DATA_W    = NETWORK_WIDTH,
    parameter  int unsigned IDX_W     = INDEX_WIDTH,
    localparam int unsigned LANES     = 1 << LOG_LANES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_descend,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES*IDX_W-1:0]  in_index,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES*IDX_W-1:0]  out_index,
    output logic                    busy
);

    localparam int unsigned STAGES = sort_stages(LOG_LANES);

    logic [STAGES-1:0]       valid;
    logic [STAGES-1:0]       descend;
    logic [STAGES-1:0]       en;
    logic [LANES*DATA_W-1:0] data  [STAGES];
    logic [LANES*IDX_W-1:0]  index [STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic                    up_valid;
        logic                    up_descend;
        logic [LANES*DATA_W-1:0] up_data;
        logic [LANES*IDX_W-1:0]  up_index;

        if (s == 0) begin : g_head
            assign up_valid   = in_valid;
            assign up_descend = in_descend;
            assign up_data    = in_data;
            assign up_index   = in_index;
        end else begin : g_link
            assign up_valid   = valid[s-1];
            assign up_descend = descend[s-1];
            assign up_data    = data[s-1];
            assign up_index   = index[s-1];
        end

        // Unrolled form of en[s] = !valid[s] || en[s+1]: a layer may load unless it and
        // every layer downstream of it is full while the output is stalled.
        assign en[s] = out_ready || !(&valid[STAGES-1:s]);

        cmp_exchange_layer #(
            .LANES (LANES),
            .DATA_W(DATA_W),
            .IDX_W (IDX_W),
            .J     (stage_j(LOG_LANES, s)),
            .K     (stage_k(LOG_LANES, s))
        ) u_layer (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en[s]),
            .up_valid  (up_valid),
            .up_descend(up_descend),
            .up_data   (up_data),
            .up_index  (up_index),
            .valid     (valid[s]),
            .descend   (descend[s]),
            .data      (data[s]),
            .index     (index[s])
        );
    end

    logic unused_last_descend;
    assign unused_last_descend = descend[STAGES-1];

    assign in_ready  = en[0];
    assign out_valid = valid[STAGES-1];
    assign out_data  = data[STAGES-1];
    assign out_index = index[STAGES-1];
    assign busy      = |valid;

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Self-checking bench for bitonic_sort_pipe: value-sort reference model plus pinned vectors.
module tb_bitonic_sort_pipe;

    localparam int LOG_LANES = 2;
    localparam int LANES     = 4;
    localparam int DATA_W    = 8;
    localparam int IDX_W     = 4;
    localparam int STAGES    = LOG_LANES * (LOG_LANES + 1) / 2;
    localparam int DW        = LANES * DATA_W;
    localparam int IW        = LANES * IDX_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_descend = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [IW-1:0] in_index = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_index;
    logic          busy;

    always #5 clk = ~clk;

    bitonic_sort_pipe #(
        .LOG_LANES(LOG_LANES),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_descend(in_descend),
        .in_data   (in_data),
        .in_index  (in_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .busy      (busy)
    );

    typedef struct packed {
        logic          descend;
        logic [IW-1:0] index;
        logic [DW-1:0] data;
    } beat_t;

    beat_t q[$];
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: the values of the beat sorted in the requested direction.
    function automatic logic [DW-1:0] model_sorted(input beat_t b);
        int unsigned v[LANES];
        int unsigned t;
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) v[i] = b.data[i*DATA_W +: DATA_W];
        for (int i = 0; i < LANES; i++)
            for (int j = i + 1; j < LANES; j++)
                if (b.descend ? (v[j] > v[i]) : (v[j] < v[i])) begin
                    t = v[i]; v[i] = v[j]; v[j] = t;
                end
        r = '0;
        for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = DATA_W'(v[i]);
        return r;
    endfunction

    // Every output (value, index) pair must be an unused input pair.
    function automatic bit pairs_ok(input beat_t b, input logic [DW-1:0] od, input logic [IW-1:0] oi);
        bit used[LANES];
        bit found;
        for (int i = 0; i < LANES; i++) used[i] = 1'b0;
        for (int o = 0; o < LANES; o++) begin
            found = 1'b0;
            for (int i = 0; i < LANES; i++)
                if (!found && !used[i] &&
                    b.data[i*DATA_W +: DATA_W] == od[o*DATA_W +: DATA_W] &&
                    b.index[i*IDX_W +: IDX_W] == oi[o*IDX_W +: IDX_W]) begin
                    used[i] = 1'b1;
                    found   = 1'b1;
                end
            if (!found) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [IW-1:0] exp_idx(input logic [IW-1:0] v);
`ifdef BITONIC_SORT_INDEX_EN
        return v;
`else
        return '0;
`endif
    endfunction

    logic [DW-1:0] exp_d;
    logic [DW-1:0] held_data;
    logic [IW-1:0] held_index;
    bit            held = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held)
                check("stall_stable", {out_valid, out_index, out_data}, {1'b1, held_index, held_data});
            held = 1'b0;
            if (q.size() == 0) begin
                check("spurious_out_valid", out_valid, 0);
            end else if (out_valid) begin
                exp_d = model_sorted(q[0]);
                check("out_data", out_data, exp_d);
`ifdef BITONIC_SORT_INDEX_EN
                check("index_pairing", pairs_ok(q[0], out_data, out_index), 1);
`else
                check("out_index_zero", out_index, 0);
`endif
                if (out_ready) void'(q.pop_front());
                else begin
                    held       = 1'b1;
                    held_data  = out_data;
                    held_index = out_index;
                end
            end
            if (in_valid && in_ready)
                q.push_back('{descend: in_descend, index: in_index, data: in_data});
        end
    end

    task automatic rand_beat();
        for (int i = 0; i < LANES; i++) begin
            in_data[i*DATA_W +: DATA_W] = ($urandom_range(0, 2) == 0) ? DATA_W'($urandom_range(0, 3))
                                                                      : DATA_W'($urandom);
            in_index[i*IDX_W +: IDX_W]  = IDX_W'($urandom);
        end
        in_descend = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic send_pinned(input string name, input logic [DW-1:0] d, input logic [IW-1:0] ix,
                               input logic desc, input logic [DW-1:0] ed, input logic [IW-1:0] ei);
        wait_idle();
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_data    = d;
        in_index   = ix;
        in_descend = desc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int m = 0; m <= STAGES; m++) begin
            @(negedge clk);
            check({name, "_valid"}, out_valid, (m == STAGES - 1));
            if (m == STAGES - 1) begin
                check({name, "_data"}, out_data, ed);
                check({name, "_index"}, out_index, exp_idx(ei));
            end
        end
        @(posedge clk); #1;
    endtask

    logic [15:0] pat;
    int          acc;
    logic        took;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        send_pinned("asc", 32'h03070105, 16'h3210, 1'b0, 32'h07050301, 16'h2031);
        send_pinned("desc", 32'h03070105, 16'h3210, 1'b1, 32'h01030507, 16'h1302);
        send_pinned("ties", 32'h04020404, 16'h3210, 1'b0, 32'h04040402, 16'h3102);

        // Ten back-to-back beats: outputs on ten consecutive cycles from the 3rd edge on.
        wait_idle();
        out_ready = 1'b1;
        fork
            begin
                for (int b = 0; b < 10; b++) begin
                    rand_beat();
                    in_valid = 1'b1;
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                for (int m = 0; m < 16; m++) begin
                    @(negedge clk);
                    pat[m] = out_valid;
                end
            end
        join
        check("throughput_pattern", pat, 16'h0FFC);
        @(posedge clk); #1;

        // Backpressure: the pipeline fills with exactly STAGES beats.
        wait_idle();
        out_ready = 1'b0;
        acc = 0;
        rand_beat();
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk); #1;
            if (took) begin
                acc++;
                rand_beat();
            end
        end
        check("bp_accepted", acc, STAGES);
        check("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_reopen_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rand_beat();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            rand_beat();
        end
        in_valid = 1'b0;
        wait_idle();
        check("bp_drained", q.size(), 0);

        // Random traffic with random backpressure.
        for (int c = 0; c < 300; c++) begin
            rand_beat();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        check("rand_drained", q.size(), 0);

        // Reset with two beats in flight and one of them stalled at the output.
        out_ready = 1'b0;
        rand_beat();
        in_valid = 1'b1;
        @(posedge clk); #1;
        rand_beat();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("pre_rst_out_valid", out_valid, 1);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_data", out_data, 0);
        q.delete();
        @(negedge clk); #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_rst_no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        send_pinned("ties_after_rst", 32'h04020404, 16'h3210, 1'b0, 32'h04040402, 16'h3102);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
